pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Generic, parametrised pipeline stage register for the vector processor.
- Successor to the fixed-field stage registers. Adds a valid/ready handshake, an optional 2-entry skid buffer, and a split payload:
  - ctrl field: cleared by flush.
  - data field: held on flush.
- Instanced between any two pipeline stages (F/D, D/E, E/M, M/W). Stall and flush come from the hazard unit.

Parameters:
- CW, 16, control payload width (regw/memw/branch/vect flags, opcode, ALU ctrl, register indices); zeroed on reset and flush.
- DW, 128, data payload width (vector operands, immediate); zeroed on reset only.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash of all stage contents.
- stall  in  1  hazard freeze; blocks both handshakes.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage accepts a beat this cycle.
- in_ctrl  in  CW  upstream control payload.
- in_data  in  DW  upstream data payload.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CW  control payload of the head entry.
- out_data  out  DW  data payload of the head entry.
- occupancy  out  2  number of valid entries (0..2).

Behaviour:
- Reset (async, any time, including mid-transfer):
  - All entries become invalid immediately; ctrl and data registers clear to 0.
  - out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
  - in_ready is held 0 while rst is high.
  - First acceptance is possible on the first rising edge after rst deasserts.
- Fire conditions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Stall:
  - in_ready=0 and out_valid is forced to 0 while stall is high.
  - Entries, ctrl and data hold; occupancy holds.
- Flush (sampled at the edge):
  - All valid bits and ctrl registers clear to 0; data registers hold.
  - Flush overrides stall and any same-cycle in_fire or out_fire; an incoming beat in the flush cycle is dropped.
  - occupancy=0 the next cycle.
- Latency: 1 cycle from in_fire to the corresponding out_valid; sustained throughput of 1 beat per cycle.
- Ordering: strict FIFO; no beat is duplicated or lost except by flush.
- Entries: main (head, drives out_*) and skid (second entry, exists only with PIPE_SKID_EN).
- States (no flush, no stall):
  - EMPTY: in_fire loads main -> ONE.
  - ONE, in_fire & out_fire: main <= in, stays ONE.
  - ONE, in_fire only: skid <= in -> FULL.
  - ONE, out_fire only: -> EMPTY.
  - FULL: in_ready=0; out_fire moves main <= skid -> ONE.
- out_valid = (state != EMPTY) & ~stall.
- out_ctrl and out_data always reflect main, even when invalid.
- When main is invalid (EMPTY), ctrl is 0.

Optional Feature:
- Macro: PIPE_SKID_EN.
- Defined:
  - 2-entry skid buffer (states EMPTY/ONE/FULL).
  - in_ready = (state != FULL) & ~stall & ~rst. This is a registered state decode, with no combinational path from out_ready.
  - occupancy reaches 2.
- Undefined:
  - Single entry only (EMPTY/ONE); the FULL state and skid registers are not built.
  - in_ready = (state==EMPTY | out_ready) & ~stall & ~rst. This is a combinational path from out_ready.
  - occupancy never exceeds 1.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: assert rst mid-stream with occupancy=1 and ctrl=16'hA5A5 -> out_valid=0, out_ctrl=0, occupancy=0 the same cycle (before any edge); in_ready=0 until rst drops.
- Streaming: out_ready=1, in_valid=1 for 8 cycles with in_data=1..8 -> out_data=1..8 on consecutive cycles starting 1 cycle after the first accept; no bubbles.
- Backpressure (PIPE_SKID_EN):
  - Push beats A=1, B=2 with out_ready=0 -> occupancy=2, in_ready=0, out_data=1.
  - Release out_ready -> outputs 1 then 2; in_ready returns to 1 the cycle after the first out_fire.
- Backpressure (no PIPE_SKID_EN): out_ready=0 with occupancy=1 -> in_ready=0 in the same cycle; out_ready=1 with in_valid=1 -> pass-through replacement; occupancy stays 1.
- Stall: stall=1 for 3 cycles at occupancy=1, ctrl=16'h0042 -> out_valid=0 and in_ready=0 throughout; after stall drops, out_ctrl=16'h0042 and out_valid=1.
- Flush: flush=1 together with in_fire and occupancy=2 -> next cycle occupancy=0, out_valid=0, out_ctrl=0, out_data unchanged; the dropped beat never appears.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, flushable ctrl and held data.
// Define PIPE_SKID_EN to build the 2-entry skid buffer; otherwise a single entry is built.
module pipe_stage_skid #(
  parameter int CW = 16,
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          stall,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_ctrl,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_ctrl,
  output logic [DW-1:0] out_data,
  output logic [1:0]    occupancy
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t        state;
  logic [CW-1:0] main_ctrl;
  logic [DW-1:0] main_data;
  logic          in_fire;
  logic          out_fire;

`ifdef PIPE_SKID_EN
  logic [CW-1:0] skid_ctrl;
  logic [DW-1:0] skid_data;

  // Registered state decode only: out_ready never reaches in_ready.
  assign in_ready = (state != FULL) & ~stall & ~rst;
`else
  assign in_ready = ((state == EMPTY) | out_ready) & ~stall & ~rst;
`endif

  assign out_valid = (state != EMPTY) & ~stall;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;

  always_comb begin
    occupancy = 2'd0;
    case (state)
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      main_ctrl <= '0;
      main_data <= '0;
`ifdef PIPE_SKID_EN
      skid_ctrl <= '0;
      skid_data <= '0;
`endif
    end else if (flush) begin
      // Squash beats and their control; data payload is deliberately left in place.
      state     <= EMPTY;
      main_ctrl <= '0;
`ifdef PIPE_SKID_EN
      skid_ctrl <= '0;
`endif
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
            state     <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
`ifdef PIPE_SKID_EN
          end else if (in_fire) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
            state     <= FULL;
`endif
          end else if (out_fire) begin
            main_ctrl <= '0;
            state     <= EMPTY;
          end
        end
`ifdef PIPE_SKID_EN
        FULL: begin
          if (out_fire) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
            state     <= ONE;
          end
        end
`endif
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: queue model checked every negedge plus directed literal checks.
// Build with or without PIPE_SKID_EN to match the DUT.
module tb_pipe_stage_skid;

  localparam int CW = 16;
  localparam int DW = 128;
`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          stall = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  int n_cmp = 0;
  int n_err = 0;

  pipe_stage_skid #(.CW(CW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  beat_t         mq[$];
  logic [DW-1:0] m_hd = '0;

  function automatic logic m_out_valid();
    return (mq.size() > 0) && !stall && !rst;
  endfunction

  // Acceptance: room in the queue, or (single entry) the head leaves this cycle.
  function automatic logic m_in_ready();
    logic room;
    room = (mq.size() < CAP) || (CAP == 1 && out_ready);
    return room && !stall && !rst;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_hd = '0;
    end else if (flush) begin
      mq.delete();
    end else begin
      logic fi, fo;
      fi = in_valid && m_in_ready();
      fo = m_out_valid() && out_ready;
      if (fo) void'(mq.pop_front());
      if (fi) mq.push_back({in_ctrl, in_data});
      if (mq.size() > 0) m_hd = mq[0].d;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_out_valid", 128'(out_valid), 128'(m_out_valid()));
    chk("m_in_ready", 128'(in_ready), 128'(m_in_ready()));
    chk("m_occupancy", 128'(occupancy), 128'(mq.size()));
    chk("m_out_ctrl", 128'(out_ctrl), (mq.size() > 0) ? 128'(mq[0].c) : 128'(0));
    chk("m_out_data", 128'(out_data), (mq.size() > 0) ? 128'(mq[0].d) : 128'(m_hd));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_occupancy", 128'(occupancy), 128'(0));
    repeat (2) tick();
    rst = 1'b0;

    // Streaming 1..8
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_ctrl = CW'(i); in_data = DW'(i);
      @(negedge clk);
      if (i > 1) begin
        chk("stream_data", 128'(out_data), 128'(i - 1));
        chk("stream_valid", 128'(out_valid), 128'(1));
      end
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_last", 128'(out_data), 128'(8));
    tick();

    // Reset mid-stream
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 16'hA5A5; in_data = 128'd77;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_occ", 128'(occupancy), 128'(1));
    chk("pre_rst_ctrl", 128'(out_ctrl), 128'hA5A5);
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 128'(out_valid), 128'(0));
    chk("rst_async_ctrl", 128'(out_ctrl), 128'(0));
    chk("rst_async_occ", 128'(occupancy), 128'(0));
    chk("rst_async_data", 128'(out_data), 128'(0));
    in_valid = 1'b1; in_ctrl = 16'h0011; in_data = 128'd11;
    #1;
    chk("rst_in_ready_hi", 128'(in_ready), 128'(0));
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    chk("post_rst_occ", 128'(occupancy), 128'(1));
    chk("post_rst_data", 128'(out_data), 128'd11);
    out_ready = 1'b1;
    tick();

    // Backpressure
    out_ready = 1'b0;
`ifdef PIPE_SKID_EN
    in_valid = 1'b1; in_ctrl = 16'd1; in_data = 128'd1;
    tick();
    in_ctrl = 16'd2; in_data = 128'd2;
    tick();
    in_valid = 1'b0;
    chk("bp_occ2", 128'(occupancy), 128'(2));
    chk("bp_ready0", 128'(in_ready), 128'(0));
    chk("bp_head", 128'(out_data), 128'(1));
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_first", 128'(out_data), 128'(1));
    tick();
    chk("bp_ready_back", 128'(in_ready), 128'(1));
    chk("bp_second", 128'(out_data), 128'(2));
    tick();
    chk("bp_drained", 128'(occupancy), 128'(0));
`else
    in_valid = 1'b1; in_ctrl = 16'd1; in_data = 128'd1;
    tick();
    in_ctrl = 16'd2; in_data = 128'd2;
    chk("bp_ready0", 128'(in_ready), 128'(0));
    chk("bp_occ1", 128'(occupancy), 128'(1));
    out_ready = 1'b1;
    #1;
    chk("bp_ready_comb", 128'(in_ready), 128'(1));
    tick();
    chk("bp_replace", 128'(out_data), 128'(2));
    chk("bp_occ_stays", 128'(occupancy), 128'(1));
    in_valid = 1'b0;
    tick();
    chk("bp_drained", 128'(occupancy), 128'(0));
`endif

    // Stall
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 16'h0042; in_data = 128'h42;
    tick();
    in_ctrl = 16'h0055; in_data = 128'h55;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      out_ready = 1'b1;
      @(negedge clk);
      chk("stall_valid", 128'(out_valid), 128'(0));
      chk("stall_ready", 128'(in_ready), 128'(0));
      tick();
    end
    stall = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("stall_ctrl", 128'(out_ctrl), 128'h0042);
    chk("stall_release", 128'(out_valid), 128'(1));
    chk("stall_occ", 128'(occupancy), 128'(1));
    out_ready = 1'b1;
    tick();

    // Flush with a full stage and an offered beat
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 16'd3; in_data = 128'd3;
    tick();
`ifdef PIPE_SKID_EN
    in_ctrl = 16'd4; in_data = 128'd4;
    tick();
    chk("flush_pre_occ", 128'(occupancy), 128'(2));
`endif
    in_ctrl = 16'd9; in_data = 128'd9; out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_occ", 128'(occupancy), 128'(0));
    chk("flush_valid", 128'(out_valid), 128'(0));
    chk("flush_ctrl", 128'(out_ctrl), 128'(0));
    chk("flush_data_held", 128'(out_data), 128'(3));
    repeat (3) tick();
    chk("flush_dropped", 128'(out_valid), 128'(0));

    // Mixed traffic, checked by the model
    for (int i = 0; i < 48; i++) begin
      in_valid  = (i % 3) != 0;
      out_ready = (i % 5) != 1;
      stall     = (i % 11) == 7;
      flush     = (i == 30);
      in_ctrl   = CW'(200 + i);
      in_data   = DW'(1000 + i);
      tick();
    end
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
